// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies one 256-byte page to $2004
module oam_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  input  logic [7:0]  bus_d_in,
  output logic        rdy,
  output logic        dma_sel,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_d_out,
  output logic        dma_we,
  output logic        busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  logic [2:0] state, state_nx;
  logic       cyc_odd;
  logic [7:0] page, idx, latch;
  logic       trig;
  assign trig = cpu_we && cpu_addr == 16'h4014;
  // HALT on an odd cycle goes straight to READ so every READ lands on an even cycle
  always_comb begin
    state_nx = state == IDLE  ? (trig ? HALT : IDLE) :
               state == HALT  ? (cyc_odd ? READ : ALIGN) :
               state == ALIGN ? READ :
               state == READ  ? WRITE :
               state == WRITE ? (idx == 8'hFF ? IDLE : READ) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cyc_odd <= 1'b0;
      page    <= 8'h00;
      idx     <= 8'h00;
      latch   <= 8'h00;
    end else begin
      cyc_odd <= ~cyc_odd;
      state   <= state_nx;
      if (state == IDLE && trig) begin
        page <= cpu_d_out;
        idx  <= 8'h00;
      end
      if (state == READ) latch <= bus_d_in;
      if (state == WRITE) idx <= idx + 8'h01;
    end
  end
  assign rdy       = state == IDLE;
  assign busy      = ~rdy;
  assign dma_sel   = ~rdy;
  assign dma_we    = state == WRITE;
  assign dma_addr  = state == READ ? {page, idx} : state == WRITE ? 16'h2004 : 16'h0000;
  assign dma_d_out = state == WRITE ? latch : 8'h00;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed vector table plus multi-cycle transfer/abort sequences for oam_dma
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_d_out = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  bus_d_in;
  logic        rdy, dma_sel, dma_we, busy;
  logic [15:0] dma_addr;
  logic [7:0]  dma_d_out;
  int total = 0;
  int passed = 0;
  int ecount = 0;
  int stall_cnt = 0;
  int bad_busy = 0;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_odd = 1'b0;
  logic [7:0]  wr_q[$];
  logic [15:0] wa_q[$];
  logic [15:0] rd_q[$];
  logic        ro_q[$];

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_we(cpu_we),
    .bus_d_in(bus_d_in), .rdy(rdy), .dma_sel(dma_sel), .dma_addr(dma_addr),
    .dma_d_out(dma_d_out), .dma_we(dma_we), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[15:8] == 8'h07 ? a[7:0] ^ 8'hA5 : ~a[7:0] + a[15:8];
  endfunction
  assign bus_d_in = mem(dma_addr);

  always @(posedge clk or negedge rst)
    if (!rst) ecount <= 0;
    else ecount <= ecount + 1;

  // Each write pulse is paired with the READ cycle just before it
  always @(negedge clk) begin
    if (rst) begin
      if (!rdy) stall_cnt++;
      if (busy == rdy || dma_sel != busy) bad_busy++;
      if (dma_we) begin
        wr_q.push_back(dma_d_out);
        wa_q.push_back(dma_addr);
        rd_q.push_back(prev_addr);
        ro_q.push_back(prev_odd);
      end
      prev_addr = dma_addr;
      prev_odd = ecount[0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run(input logic [7:0] pg, input bit odd, input bit inject);
    int s0, w0, n, bd, ba, br, bo;
    n = 0;
    while (ecount[0] != odd && n < 4) begin
      @(negedge clk);
      n++;
    end
    s0 = stall_cnt;
    w0 = wr_q.size();
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_d_out = pg;
    @(negedge clk);
    cpu_we = 1'b0;
    check("start_rdy", rdy, 1'b0);
    n = 0;
    while (rdy == 1'b0 && n < 700) begin
      if (inject && dma_addr == {pg, 8'h40}) begin
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_d_out = 8'h05;
      end else cpu_we = 1'b0;
      @(negedge clk);
      n++;
    end
    cpu_we = 1'b0;
    #1;
    check("done_rdy", rdy, 1'b1);
    check("stall_len", stall_cnt - s0, odd ? 514 : 513);
    check("write_cnt", wr_q.size() - w0, 256);
    bd = 0; ba = 0; br = 0; bo = 0;
    for (int k = 0; k < 256; k++) begin
      if (w0 + k >= wr_q.size()) begin
        bd++; ba++; br++; bo++;
      end else begin
        if (wr_q[w0+k] !== mem({pg, k[7:0]})) bd++;
        if (wa_q[w0+k] !== 16'h2004) ba++;
        if (rd_q[w0+k] !== {pg, k[7:0]}) br++;
        if (ro_q[w0+k] !== 1'b0) bo++;
      end
    end
    check("data_bad", bd, 0);
    check("waddr_bad", ba, 0);
    check("raddr_bad", br, 0);
    check("read_odd", bo, 0);
    if (w0 < rd_q.size()) check("first_read", rd_q[w0], {pg, 8'h00});
    if (w0 + 255 < rd_q.size()) check("last_read", rd_q[w0+255], {pg, 8'hFF});
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  d;
    logic        exp_rdy;
    logic        exp_sel;
    logic [15:0] exp_addr;
    logic        exp_we;
  } vec_t;
  vec_t vt[7];

  initial begin
    int n, w0;
    vt[0] = '{1'b1, 16'h4015, 8'hFF, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[1] = '{1'b0, 16'h4014, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[2] = '{1'b1, 16'h4013, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[3] = '{1'b1, 16'h0014, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[4] = '{1'b1, 16'hC014, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[6] = '{1'b1, 16'h4014, 8'h09, 1'b0, 1'b1, 16'h0000, 1'b0};
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_sel", dma_sel, 1'b0);
    check("rst_we", dma_we, 1'b0);
    check("rst_addr", dma_addr, 16'h0000);
    check("rst_dout", dma_d_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    foreach (vt[i]) begin
      cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_d_out = vt[i].d;
      @(negedge clk);
      cpu_we = 1'b0;
      check($sformatf("vec%0d_rdy", i), rdy, vt[i].exp_rdy);
      check($sformatf("vec%0d_sel", i), dma_sel, vt[i].exp_sel);
      check($sformatf("vec%0d_addr", i), dma_addr, vt[i].exp_addr);
      check($sformatf("vec%0d_we", i), dma_we, vt[i].exp_we);
    end
    n = 0;
    while (!rdy && n < 700) begin
      @(negedge clk);
      n++;
    end
    check("vec_done", rdy, 1'b1);
    @(negedge clk);
    run(8'h02, 1'b0, 1'b1);
    run(8'h03, 1'b1, 1'b0);
    run(8'h07, 1'b0, 1'b0);
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_d_out = 8'h04;
    @(negedge clk);
    cpu_we = 1'b0;
    n = 0;
    while (dma_addr != 16'h0480 && n < 700) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach", dma_addr, 16'h0480);
    @(negedge clk);
    check("abort_pre_we", dma_we, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_rdy", rdy, 1'b1);
    check("abort_we", dma_we, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", dma_addr, 16'h0000);
    check("abort_dout", dma_d_out, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    w0 = wr_q.size();
    repeat (30) @(negedge clk);
    check("post_abort_writes", wr_q.size() - w0, 0);
    check("post_abort_rdy", rdy, 1'b1);
    check("post_abort_sel", dma_sel, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(8'h07, 1'b0, 1'b0);
    check("busy_vs_rdy", bad_busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
